// File: rtl/control_pipe_pkg.sv
// control_pipe_pkg: opcode/funct encodings, control-bundle layout and FSM
// state encoding shared by the registered decoder and its combinational table.
// MFC0, MTC0 and ERET are given distinct primary opcodes in this ISA subset,
// because the decoder only sees opcode and funct.
package control_pipe_pkg;

  localparam int CTRL_WIDTH = 14;

  // Primary opcodes (instruction [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MFC0  = 6'h10;
  localparam logic [5:0] OP_MTC0  = 6'h11;
  localparam logic [5:0] OP_ERET  = 6'h12;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction [5:0])
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MULT    = 6'h18;

  // Bit positions inside the ctrl bundle (MSB first)
  localparam int C_REGWRITE = 13;
  localparam int C_MEMTOREG = 12;
  localparam int C_MEMREAD  = 11;
  localparam int C_MEMWRITE = 10;
  localparam int C_MEMBYTE  = 9;
  localparam int C_ISBRANCH = 8;
  localparam int C_ISJUMP   = 7;
  localparam int C_JUMPDST  = 6;
  localparam int C_ISLINK   = 5;
  localparam int C_REGDST   = 4;
  localparam int C_ALUOP    = 3;
  localparam int C_ALU_S    = 2;
  localparam int C_ALU_T    = 1;
  localparam int C_COWRITE  = 0;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: pure combinational decode table, opcode/funct/user_mode to
// the ctrl bundle and exception flags. With CONTROL_MUL_EN defined, R-type
// FN_MULT is flagged on is_mult so the top level can start MULT sequencing;
// otherwise MULT decodes as a plain R-type instruction.
module control_decode
  import control_pipe_pkg::*;
(
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  user_mode,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  exc_ri,
  output logic                  exc_sys,
  output logic                  exc_ret,
  output logic                  is_mult
);

  // Table lookup; anything not listed is a reserved instruction.
  always_comb begin
    ctrl    = '0;
    exc_ri  = 1'b0;
    exc_sys = 1'b0;
    exc_ret = 1'b0;
    is_mult = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR: begin
            ctrl[C_ISJUMP]  = 1'b1;
            ctrl[C_JUMPDST] = 1'b1;
          end
          FN_SYSCALL: exc_sys = 1'b1;
`ifdef CONTROL_MUL_EN
          FN_MULT: begin
            ctrl[C_REGWRITE] = 1'b1;
            ctrl[C_REGDST]   = 1'b1;
            is_mult          = 1'b1;
          end
`endif
          default: begin
            ctrl[C_REGWRITE] = 1'b1;
            ctrl[C_REGDST]   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: begin
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_ALU_T]    = 1'b1;
        ctrl[C_ALUOP]    = 1'b1;
      end
      OP_LW, OP_LB: begin
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_MEMTOREG] = 1'b1;
        ctrl[C_MEMREAD]  = 1'b1;
        ctrl[C_ALU_T]    = 1'b1;
        ctrl[C_ALUOP]    = 1'b1;
        ctrl[C_MEMBYTE]  = (opcode == OP_LB);
      end
      OP_SW, OP_SB: begin
        ctrl[C_MEMWRITE] = 1'b1;
        ctrl[C_ALU_T]    = 1'b1;
        ctrl[C_ALUOP]    = 1'b1;
        ctrl[C_MEMBYTE]  = (opcode == OP_SB);
      end
      OP_J, OP_JAL: begin
        ctrl[C_ISJUMP]   = 1'b1;
        ctrl[C_ALUOP]    = 1'b1;
        ctrl[C_REGWRITE] = (opcode == OP_JAL);
        ctrl[C_ISLINK]   = (opcode == OP_JAL);
      end
      OP_BEQ, OP_BNE: begin
        ctrl[C_ISBRANCH] = 1'b1;
        ctrl[C_ALUOP]    = 1'b1;
      end
      OP_MFC0: begin
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_ALU_S]    = 1'b1;
        ctrl[C_ALUOP]    = 1'b1;
        exc_ri           = user_mode;
      end
      OP_MTC0: begin
        ctrl[C_ALUOP]   = 1'b1;
        ctrl[C_COWRITE] = !user_mode;
        exc_ri          = user_mode;
      end
      OP_ERET: begin
        exc_ri  = user_mode;
        exc_ret = !user_mode;
      end
      default: exc_ri = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: registered, handshaked control decoder between IF/ID and
// ID/EX. Holds its output under stall_in, honours flush, and with
// CONTROL_MUL_EN defined blocks the front end for MUL_LAT cycles after
// accepting a MULT.
//
// Handshake: an instruction is accepted when in_valid && in_ready. in_ready
// depends only on reset, FSM state, out_valid and stall_in (never on
// opcode/funct). out_valid/ctrl/exc_* are held unchanged while
// out_valid && stall_in; otherwise out_valid falls the cycle after an
// unaccepted cycle.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CTRL_W  = CTRL_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              user_mode,
  input  logic              stall_in,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic              exc_ri,
  output logic              exc_sys,
  output logic              exc_ret,
  output logic              mul_busy
);

  // Counter is loaded with MUL_LAT-1 so MUL lasts exactly MUL_LAT cycles.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [CTRL_WIDTH-1:0] d_ctrl;
  logic                  d_ri, d_sys, d_ret, d_mult;
  logic                  accept;

  control_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .user_mode (user_mode),
    .ctrl      (d_ctrl),
    .exc_ri    (d_ri),
    .exc_sys   (d_sys),
    .exc_ret   (d_ret),
    .is_mult   (d_mult)
  );

  assign in_ready = reset && (state == ST_RUN) && !(out_valid && stall_in);
  assign accept   = in_valid && in_ready;
  assign mul_busy = (state == ST_MUL);

  // FSM state and MULT counter; reset and flush both abort sequencing.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: enter MUL on an accepted MULT, leave after the counter hits 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_RUN: begin
        if (accept && d_mult) begin
          state_n = ST_MUL;
          cnt_n   = MUL_LOAD;
        end
      end
      ST_MUL: begin
        if (cnt == 4'd0) state_n = ST_RUN;
        else             cnt_n   = cnt - 4'd1;
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
  end

  // Output register: load on accept, hold under stall, drop valid when drained.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      exc_ri    <= 1'b0;
      exc_sys   <= 1'b0;
      exc_ret   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl      <= d_ctrl;
      exc_ri    <= d_ri;
      exc_sys   <= d_sys;
      exc_ret   <= d_ret;
    end else if (out_valid && !stall_in) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Registered, handshaked successor to the combinational instruction decoder, sitting between IF/ID and the ID/EX register of the MIPS pipeline.
- Decodes `opcode`/`funct` into the control bundle and registers it behind a valid/ready handshake.
- Honours downstream stall and flush.
- Raises `exc_ri` for unknown opcodes instead of only warning.
- Sequences a multi-cycle MULT by holding the front end for a parametrised latency.

## Interface
- `MUL_LAT`, default 4: cycles `mul_busy` stays high after a MULT is accepted; legal range 1..15.
- `CTRL_W`, default 14: width of the `ctrl` bundle; must equal the package constant.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `in_valid` in 1: IF/ID holds an instruction.
- `in_ready` out 1: decoder accepts this cycle (combinational).
- `opcode` in 6: instruction [31:26].
- `funct` in 6: instruction [5:0].
- `user_mode` in 1: privilege level, sampled on accept.
- `stall_in` in 1: EX cannot take the output.
- `flush` in 1: kill the held and in-flight instruction.
- `out_valid` out 1: `ctrl`/`exc_*` valid.
- `ctrl` out `CTRL_W`: packed regwrite, memtoreg, memread, memwrite, membyte, isbranch, isjump, jumpdst, islink, regdst, aluop, alu_s, alu_t, cowrite (MSB→LSB).
- `exc_ri`, `exc_sys`, `exc_ret` out 1 each.
- `mul_busy` out 1: MULT sequencing in progress.

## Operation
Accept and hold:
- Accept = `in_valid && in_ready`.
- `in_ready = reset && state==RUN && !(out_valid && stall_in)`.
- On accept, the decoded bundle and `exc_*` are written to the output register and `out_valid` is 1 next cycle.
- With `out_valid && stall_in`, all outputs are held unchanged.
- With `out_valid && !stall_in` and no accept, `out_valid` drops to 0 next cycle.

Decode table:
- R-type default: regwrite, regdst.
- JR: isjump, jumpdst.
- SYSCALL: exc_sys.
- ADDI/ANDI/ORI/XORI/SLTI/LUI: regwrite, alu_t, aluop.
- LW: regwrite, memtoreg, memread, alu_t, aluop.
- LB: as LW plus membyte.
- SW: memwrite, alu_t, aluop.
- SB: as SW plus membyte.
- J: isjump, aluop.
- JAL: J plus regwrite, islink.
- BEQ/BNE: isbranch, aluop.
- MFC0: regwrite, alu_s, aluop, `exc_ri=user_mode`.
- MTC0: aluop, `exc_ri=user_mode`, `cowrite=!user_mode`.
- ERET: `exc_ri=user_mode`, `exc_ret=!user_mode`.
- Any other opcode: all ctrl 0, `exc_ri=1`.

States:
- RUN: normal operation.
- MUL: entered on accepting R-type funct FN_MULT (0x18).
  - Counter is loaded with `MUL_LAT-1` and `mul_busy=1`.
  - Counter decrements each cycle; returns to RUN in the cycle after the counter reads 0.
  - `in_ready=0` throughout MUL. The MULT's own bundle (R-type default) is presented normally on `out_valid`.

Flush:
- Registered result next cycle: `out_valid=0`, `exc_*=0`, state RUN, counter 0, `mul_busy=0`.
- Flush wins over a simultaneous accept; the accepted instruction is dropped.

Reset (`reset=0` at a clock edge):
- All outputs 0, state RUN, counter 0; `in_ready=0` while reset is low.
- Reset during MUL aborts it identically to flush.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Full-rate throughput with `stall_in=0` and no MULT.
- MULT blocks acceptance for exactly `MUL_LAT` cycles following its accept cycle.
- `stall_in` asserted during MUL does not pause the counter.
- `in_ready` has no combinational path from `opcode`/`funct`.

## Configuration
- `CONTROL_MUL_EN` defined: MUL state, counter, `mul_busy` and FN_MULT decode are present.
- Undefined: FN_MULT decodes as R-type default with no sequencing; `mul_busy` is tied 0; the FSM is RUN only.

## Structure
- Add `OP_*`, `FN_*` (including new `FN_MULT` 0x18), `CTRL_W`, ctrl bit-index constants and state encodings to `defines.v`.
- One sub-module, `control_decode`: the pure combinational table (opcode, funct, user_mode → ctrl, exc_*).
- The top level holds the output register, FSM, counter and handshake.

## Test plan
- Back-to-back LW (0x23), SW (0x2B), BEQ (0x04), `stall_in=0`: each appears 1 cycle after accept; LW ctrl has regwrite/memtoreg/memread/alu_t/aluop = 1.
- ADDI accepted, `stall_in=1` for 3 cycles: outputs stable, `in_ready=0`; after release the next instruction appears 1 cycle later.
- Opcode 0x3F: `exc_ri=1`, ctrl=0. MTC0 with `user_mode=1`: `exc_ri=1`, `cowrite=0`; with `user_mode=0`: `cowrite=1`.
- MULT with `MUL_LAT=4`: `mul_busy` high for 4 cycles, `in_ready` low for those 4, next instruction accepted in cycle 5.
- MULT then `flush` in the second busy cycle: next cycle `mul_busy=0`, `out_valid=0`, `in_ready=1`.
- `reset` low mid-MUL with `out_valid=1`: next cycle all outputs 0; after release, the first accept decodes normally.
